// File: rtl/raccoon_pkg.sv
// Shared constants and types for the Raccoon 25-bit coefficient datapath.
package raccoon_pkg;

    // Coefficient and derived widths
    localparam int COEF_W = 25;
    localparam int SQ_W   = 48;   // centred abs < 2^24, so its square fits in 48 bits
    localparam int LANES  = 2;    // two coefficients per packed beat

    // Supported moduli and their centring thresholds H = (q-1)/2
    localparam logic [COEF_W-1:0] Q_25 = 25'd33292289;
    localparam logic [COEF_W-1:0] Q_24 = 25'd16515073;
    localparam logic [COEF_W-1:0] H_25 = 25'd16646144;
    localparam logic [COEF_W-1:0] H_24 = 25'd8257536;

    // Modulus select encoding carried on q_mod
    typedef enum logic {
        Q_SEL_25 = 1'b0,
        Q_SEL_24 = 1'b1
    } q_sel_e;

    // Per-beat tag that travels alongside the data through the pipeline
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } beat_tag_t;

    // Modulus for a given select
    function automatic logic [COEF_W-1:0] q_of(input logic q_mod);
        return (q_mod == Q_SEL_24) ? Q_24 : Q_25;
    endfunction

    // Centring threshold for a given select
    function automatic logic [COEF_W-1:0] half_of(input logic q_mod);
        return (q_mod == Q_SEL_24) ? H_24 : H_25;
    endfunction

endpackage

// File: rtl/coef_center_abs_25.sv
// Centred absolute value of one coefficient modulo q, registered (pipeline S1).
// Coefficients at or above q are flagged and contribute zero magnitude.
module coef_center_abs_25
    import raccoon_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              q_mod,
    input  logic [COEF_W-1:0] coef,
    output logic [COEF_W-1:0] abs_val,
    output logic              err
);

    logic [COEF_W-1:0] q_sel;
    logic [COEF_W-1:0] h_sel;
    logic [COEF_W-1:0] abs_d;
    logic [COEF_W-1:0] abs_q;
    logic              err_d;
    logic              err_q;

    // Fold the coefficient into [0, H]; hold the previous result on idle cycles
    always_comb begin
        q_sel = q_of(q_mod);
        h_sel = half_of(q_mod);
        abs_d = abs_q;
        err_d = err_q;
        if (en) begin
            if (coef >= q_sel) begin
                abs_d = '0;
                err_d = 1'b1;
            end else if (coef > h_sel) begin
                abs_d = q_sel - coef;
                err_d = 1'b0;
            end else begin
                abs_d = coef;
                err_d = 1'b0;
            end
        end
    end

    // S1 result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abs_q <= '0;
            err_q <= 1'b0;
        end else begin
            abs_q <= abs_d;
            err_q <= err_d;
        end
    end

    assign abs_val = abs_q;
    assign err     = err_q;

endmodule

// File: rtl/poly_norm_check_25.sv
// Streaming infinity-norm / squared-L2-norm checker for two-lane packed
// polynomial coefficients. Beats are framed by a free-running pair counter;
// at the end of each frame a one-cycle done pulse carries the verdict.
// Pipeline: input capture -> S1 centre/abs -> S2 square -> S3 accumulate -> S4 compare.
module poly_norm_check_25
    import raccoon_pkg::*;
#(
    parameter int N_PAIRS = 256,
    parameter int ACC_W   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_flag,
    input  logic                  q_mod,
    input  logic [2*COEF_W-1:0]   din,
    input  logic [COEF_W-1:0]     bound_inf,
    input  logic [ACC_W-1:0]      bound_l2,
    output logic                  done,
    output logic                  pass,
    output logic [COEF_W-1:0]     max_abs,
    output logic [ACC_W-1:0]      sum_sq,
    output logic                  range_err
);

    localparam int               CNT_W    = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PAIRS - 1);

    // ------------------------------------------------------------------
    // Input capture: beat counter, tags and packed data
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     cnt_d,     cnt_q;
    beat_tag_t            s0_tag_d,  s0_tag_q;
    logic [2*COEF_W-1:0]  s0_din_d,  s0_din_q;
    logic                 s0_qmod_d, s0_qmod_q;

    // Tag each accepted beat by its position in the frame and advance the counter
    always_comb begin
        cnt_d          = cnt_q;
        s0_tag_d.vld   = in_flag;
        s0_tag_d.first = in_flag && (cnt_q == '0);
        s0_tag_d.last  = in_flag && (cnt_q == CNT_LAST);
        s0_din_d       = s0_din_q;
        s0_qmod_d      = s0_qmod_q;
        if (in_flag) begin
            cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            s0_din_d  = din;
            s0_qmod_d = q_mod;
        end
    end

    // Input capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            s0_tag_q  <= '0;
            s0_din_q  <= '0;
            s0_qmod_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            s0_tag_q  <= s0_tag_d;
            s0_din_q  <= s0_din_d;
            s0_qmod_q <= s0_qmod_d;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline alongside S1 and S2 (tags are already gated by vld)
    // ------------------------------------------------------------------
    beat_tag_t s1_tag_d, s1_tag_q;
    beat_tag_t s2_tag_d, s2_tag_q;

    // Tags simply shift one stage per clock
    always_comb begin
        s1_tag_d = s0_tag_q;
        s2_tag_d = s1_tag_q;
    end

    // Tag registers for S1 and S2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_tag_q <= '0;
            s2_tag_q <= '0;
        end else begin
            s1_tag_q <= s1_tag_d;
            s2_tag_q <= s2_tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane S1 (centre/abs) and S2 (square); lane 1 is A, lane 0 is B
    // ------------------------------------------------------------------
    logic [LANES-1:0][SQ_W-1:0]   s2_sq;
    logic [LANES-1:0][COEF_W-1:0] s2_abs;
    logic [LANES-1:0]             s2_err;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [COEF_W-1:0] s1_abs;
            logic              s1_err;
            logic [SQ_W-1:0]   sq_d,   sq_q;
            logic [COEF_W-1:0] abs_d,  abs_q;
            logic              err_d,  err_q;

            coef_center_abs_25 u_center (
                .clk     (clk),
                .rst     (rst),
                .en      (s0_tag_q.vld),
                .q_mod   (s0_qmod_q),
                .coef    (s0_din_q[gi*COEF_W +: COEF_W]),
                .abs_val (s1_abs),
                .err     (s1_err)
            );

            // Square the lane magnitude; keep abs and err aligned for the accumulator
            always_comb begin
                sq_d  = sq_q;
                abs_d = abs_q;
                err_d = err_q;
                if (s1_tag_q.vld) begin
                    sq_d  = SQ_W'(s1_abs) * SQ_W'(s1_abs);
                    abs_d = s1_abs;
                    err_d = s1_err;
                end
            end

            // S2 lane registers
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sq_q  <= '0;
                    abs_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    sq_q  <= sq_d;
                    abs_q <= abs_d;
                    err_q <= err_d;
                end
            end

            assign s2_sq[gi]  = sq_q;
            assign s2_abs[gi] = abs_q;
            assign s2_err[gi] = err_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // S3: frame accumulators
    // ------------------------------------------------------------------
    logic [COEF_W-1:0] lane_max;
    logic [ACC_W-1:0]  beat_sum;
    logic              beat_err;
    logic [COEF_W-1:0] acc_max_d, acc_max_q;
    logic [ACC_W-1:0]  acc_sum_d, acc_sum_q;
    logic              acc_err_d, acc_err_q;
    logic              s3_vld_d,  s3_vld_q;
    logic              s3_last_d, s3_last_q;

    // A first beat restarts the frame totals; other beats fold into them
    always_comb begin
        lane_max  = (s2_abs[1] > s2_abs[0]) ? s2_abs[1] : s2_abs[0];
        beat_sum  = ACC_W'(s2_sq[1]) + ACC_W'(s2_sq[0]);
        beat_err  = |s2_err;
        acc_max_d = acc_max_q;
        acc_sum_d = acc_sum_q;
        acc_err_d = acc_err_q;
        s3_vld_d  = s2_tag_q.vld;
        s3_last_d = s2_tag_q.last;
        if (s2_tag_q.vld) begin
            if (s2_tag_q.first) begin
                acc_max_d = lane_max;
                acc_sum_d = beat_sum;
                acc_err_d = beat_err;
            end else begin
                acc_max_d = (lane_max > acc_max_q) ? lane_max : acc_max_q;
                acc_sum_d = acc_sum_q + beat_sum;
                acc_err_d = acc_err_q | beat_err;
            end
        end
    end

    // S3 accumulator registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_max_q <= '0;
            acc_sum_q <= '0;
            acc_err_q <= 1'b0;
            s3_vld_q  <= 1'b0;
            s3_last_q <= 1'b0;
        end else begin
            acc_max_q <= acc_max_d;
            acc_sum_q <= acc_sum_d;
            acc_err_q <= acc_err_d;
            s3_vld_q  <= s3_vld_d;
            s3_last_q <= s3_last_d;
        end
    end

    // ------------------------------------------------------------------
    // S4: compare against the bounds and hold the frame result
    // ------------------------------------------------------------------
    logic              done_d,      done_q;
    logic              pass_d,      pass_q;
    logic [COEF_W-1:0] max_abs_d,   max_abs_q;
    logic [ACC_W-1:0]  sum_sq_d,    sum_sq_q;
    logic              range_err_d, range_err_q;

    // Latch the verdict when the last beat of a frame leaves the accumulator
    always_comb begin
        done_d      = s3_vld_q && s3_last_q;
        pass_d      = pass_q;
        max_abs_d   = max_abs_q;
        sum_sq_d    = sum_sq_q;
        range_err_d = range_err_q;
        if (done_d) begin
            max_abs_d   = acc_max_q;
            sum_sq_d    = acc_sum_q;
            range_err_d = acc_err_q;
            pass_d      = (acc_max_q <= bound_inf) && (acc_sum_q <= bound_l2) && !acc_err_q;
        end
    end

    // S4 output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            max_abs_q   <= '0;
            sum_sq_q    <= '0;
            range_err_q <= 1'b0;
        end else begin
            done_q      <= done_d;
            pass_q      <= pass_d;
            max_abs_q   <= max_abs_d;
            sum_sq_q    <= sum_sq_d;
            range_err_q <= range_err_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign max_abs   = max_abs_q;
    assign sum_sq    = sum_sq_q;
    assign range_err = range_err_q;

endmodule

// File: doc/poly_norm_check_25.md
# poly_norm_check_25

Streaming norm checker placed directly downstream of the 25-bit two-lane polynomial subtractor. It consumes the subtractor's packed coefficient pairs (`dout`/`out_flag`) and maps each coefficient to its centred absolute value modulo q. Over one polynomial frame it tracks the infinity norm and the squared L2 norm. At frame end it pulses `done` with a pass/fail verdict against programmable bounds, which gives the signature-side rejection check in the Raccoon datapath.

## Interface
Parameters:
- `N_PAIRS`, 256: coefficient pairs per frame (512 coefficients).
- `ACC_W`, 64: width of the squared-L2 accumulator.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in_flag`, input, 1: beat valid; connects to the subtractor's `out_flag`.
- `q_mod`, input, 1: modulus select; 0 → q=33292289, 1 → q=16515073.
- `din`, input, 50: packed pair; coefficient A in [49:25], coefficient B in [24:0].
- `bound_inf`, input, 25: inclusive infinity-norm bound.
- `bound_l2`, input, ACC_W: inclusive squared-L2 bound.
- `done`, output, 1: one-cycle pulse at frame result.
- `pass`, output, 1: verdict; valid when `done`=1 and held until the next `done`.
- `max_abs`, output, 25: frame infinity norm; held.
- `sum_sq`, output, ACC_W: frame sum of squares; held.
- `range_err`, output, 1: some coefficient in the frame was ≥ q; held.

## Operation
- Per lane, centring uses H=(q−1)/2. If c ≤ H, then abs=c. If H < c < q, then abs=q−c. If c ≥ q, then abs=0 and the lane error bit is set.
- Square: abs², 48 bits, zero-extended to ACC_W.
- Beat counter `cnt`, 0..N_PAIRS−1, advances on each `in_flag`. The beat with cnt=0 is tagged `first`, and the beat with cnt=N_PAIRS−1 is tagged `last`; after `last` the counter wraps to 0.
- Tags travel with the data down the pipeline.
- Accumulate stage, on a `first` beat: it loads max=max(absA,absB), sum=sqA+sqB and err=errA|errB, without combining with prior values.
- Accumulate stage, on any other beat: max=max(max,absA,absB), sum=sum+sqA+sqB, err|=errA|errB.
- The sum wraps modulo 2^ACC_W. It cannot overflow at the defaults (bound 2^57).
- On the `last` beat, the frame result is pass = (max ≤ bound_inf) & (sum ≤ bound_l2) & ~err.
- `q_mod` is sampled per beat and must be held constant within a frame by the system. The bounds are sampled in the cycle the `last` beat reaches the compare stage.
- Gaps in `in_flag` are allowed anywhere. Back-to-back frames are allowed with no idle cycle, and a new frame's `first` beat may enter while the previous frame drains.

## Timing
- Pipeline stages:
  - S1 registers abs and err per lane.
  - S2 registers the squares.
  - S3 is the accumulators.
  - S4 is the compare and output registers.
- Latency: a `last` beat sampled at edge t gives `done`=1 during the cycle after edge t+4, and updates `max_abs`, `sum_sq`, `range_err` and `pass` at the same edge.
- `done` is high for exactly one cycle per frame.
- Reset (async assert, `rst`=0):
  - `cnt`=0, all pipeline valids and tags cleared.
  - `done`=0, `pass`=0, `max_abs`=0, `sum_sq`=0, `range_err`=0.
- Reset mid-frame: the partial frame is discarded, and the first beat after reset is `first`.
- When `in_flag`=0, nothing advances state; the pipeline valid bits propagate as 0.

## Structure
- Shared package `raccoon_pkg`:
  - `Q_25`=33292289, `Q_24`=16515073.
  - Half constants `H_25`=16646144, `H_24`=8257536.
  - Coefficient width `COEF_W`=25.
- Sub-module `coef_center_abs_25`: one coefficient plus `q_mod` in, registered abs and err out (S1). It is instantiated twice, once per lane.
- The top level holds the counter, the tag pipeline, the squarers, the accumulators and the compare.

## Test plan
- All-zero frame (256 beats of `din`=0), bounds 0/0 → `done` once, `pass`=1, `max_abs`=0, `sum_sq`=0.
- One beat A=q−1, B=1 with `q_mod`=0, all others 0 → `max_abs`=1, `sum_sq`=2. The same frame with A=H_25+1 gives `max_abs`=16646144.
- Bound edge: frame max 1000, `bound_inf`=1000 → `pass`=1. With `bound_inf`=999 → `pass`=0. Repeat for `bound_l2` at exactly `sum_sq` and at `sum_sq`−1.
- Out-of-range coefficient: A=33292289 with `q_mod`=0 → `range_err`=1, `pass`=0. With `q_mod`=1, A=16515073 → the same result.
- Two back-to-back frames with randomized `in_flag` gaps → two `done` pulses, each exactly 4 edges after its `last` beat; the second frame's results are independent of the first.
- Assert `rst`=0 after 100 beats, release, then send a full frame → exactly one `done`, with values from the post-reset frame only.
